// File: rtl/cpu4_loader.sv
// Program loader and result capture sequencer for the 4-bit accumulator core:
// buffers a 9-byte host frame, drives Reset/LoadCode/LoadData/Run, captures {pc, acc}.
module cpu4_loader (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    input  logic       abort,
    output logic [7:0] cpu_ui,
    input  logic [7:0] cpu_uo,
    output logic       busy,
    output logic       result_valid,
    output logic [6:0] result
);

    typedef enum logic [2:0] {
        IDLE, RST0, CODE, RST1, DATA, RST2, RUN, DONE
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  run_n_q, run_n_d;
    logic [7:0]  run_cnt_q, run_cnt_d;
    logic [6:0]  result_q, result_d;
    logic        result_valid_q, result_valid_d;
    logic [5:0]  slot_q [8];
    logic [2:0]  idx;
    logic        accept;
    logic        unused_uo_msb;

    assign idx           = cnt_q[2:0];
    assign accept        = in_valid && (state_q == IDLE);
    assign in_ready      = (state_q == IDLE);
    assign busy          = (state_q != IDLE);
    assign result        = result_q;
    assign result_valid  = result_valid_q;
    assign unused_uo_msb = cpu_uo[7];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            run_n_q        <= '0;
            run_cnt_q      <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            run_n_q        <= run_n_d;
            run_cnt_q      <= run_cnt_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
        end
    end

    // Slot buffer is pure datapath; a reset only clears the byte counter.
    always_ff @(posedge clk) begin
        if (rst_n && accept && (cnt_q != 4'd0)) begin
            slot_q[3'(cnt_q - 4'd1)] <= in_data[5:0];
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        run_n_d        = run_n_q;
        run_cnt_d      = run_cnt_q;
        result_d       = result_q;
        result_valid_d = 1'b0;
        cpu_ui         = 8'h00;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (cnt_q == 4'd0) begin
                        run_n_d = in_data;
                    end
                    if (cnt_q == 4'd8) begin
                        cnt_d   = '0;
                        state_d = RST0;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            RST0: begin
                cnt_d   = '0;
                state_d = CODE;
            end
            CODE: begin
                cpu_ui = {2'b00, slot_q[idx][5:4], 4'b0010};
                if (idx == 3'd7) begin
                    cnt_d   = '0;
                    state_d = RST1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            RST1: begin
                cnt_d   = '0;
                state_d = DATA;
            end
            DATA: begin
                cpu_ui = {slot_q[idx][3:0], 4'b0100};
                if (idx == 3'd7) begin
                    cnt_d   = '0;
                    state_d = RST2;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            RST2: begin
                run_cnt_d = run_n_q;
                state_d   = RUN;
            end
            RUN: begin
                // A count of 0 wraps through 255 down to 1, giving 256 Run cycles.
                cpu_ui    = 8'h06;
                run_cnt_d = run_cnt_q - 8'd1;
                if (abort || (run_cnt_q == 8'd1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                result_d       = cpu_uo[6:0];
                result_valid_d = 1'b1;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
